// File: rtl/mcdf_pkt_arbiter_if.sv
// Arbiter-side bundle: control fields, FIFO heads and pops, formatter stream.
// master = arbiter, slave = the surrounding FIFOs/registers/formatter.
interface mcdf_pkt_arbiter_if #(
  parameter int DW = 32,
  parameter int CW = 6
);
  logic [2:0]      slv_en_i;
  logic [5:0]      slv_prio_i;
  logic [8:0]      slv_len_i;
  logic [3*CW-1:0] slv_cnt_i;
  logic [3*DW-1:0] slv_data_i;
  logic [2:0]      slv_rd_o;
  logic            f2a_rdy_i;
  logic            a2f_val_o;
  logic [DW-1:0]   a2f_data_o;
  logic [1:0]      a2f_id_o;
  logic [5:0]      a2f_len_o;
  logic            a2f_sop_o;
  logic            a2f_eop_o;
  logic            busy_o;

  modport master (
    input  slv_en_i, slv_prio_i, slv_len_i, slv_cnt_i, slv_data_i, f2a_rdy_i,
    output slv_rd_o, a2f_val_o, a2f_data_o, a2f_id_o, a2f_len_o, a2f_sop_o,
           a2f_eop_o, busy_o
  );

  modport slave (
    output slv_en_i, slv_prio_i, slv_len_i, slv_cnt_i, slv_data_i, f2a_rdy_i,
    input  slv_rd_o, a2f_val_o, a2f_data_o, a2f_id_o, a2f_len_o, a2f_sop_o,
           a2f_eop_o, busy_o
  );
endinterface

// File: rtl/mcdf_pkt_arbiter.sv
// Packet arbiter: locks one eligible MCDF channel per packet and streams it to the formatter.
// 2 cycles from eligibility to first word; f2a_rdy_i low holds the word and suppresses the pop.
module mcdf_pkt_arbiter #(
  parameter int DW = 32,
  parameter int CW = 6
) (
  input logic                clk_i,
  input logic                rstn_i,
  mcdf_pkt_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic [1:0] last_gnt_q, last_gnt_d;
  logic [5:0] gnt_len_q, gnt_len_d;
  logic [5:0] cnt_q, cnt_d;

  logic [1:0] prio_a [3];
  logic [2:0] len_a  [3];
  logic [2:0] elig;
  logic       any_elig;
  logic [1:0] best_prio;
  logic       found;
  logic       taken;
  logic [2:0] scan;
  logic [1:0] win_id;
  logic [5:0] win_len;
  logic       beat;

  function automatic logic [5:0] dec_len(input logic [2:0] code);
    case (code)
      3'd0:    dec_len = 6'd4;
      3'd1:    dec_len = 6'd8;
      3'd2:    dec_len = 6'd16;
      default: dec_len = 6'd32;
    endcase
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      prio_a[k] = bus.slv_prio_i[2*k +: 2];
      len_a[k]  = bus.slv_len_i[3*k +: 3];
      elig[k]   = bus.slv_en_i[k] &&
                  (bus.slv_cnt_i[CW*k +: CW] >= CW'(dec_len(len_a[k])));
    end
    any_elig = |elig;
  end

  // Lowest priority value wins; ties go to the first match scanning from last_gnt+1.
  always_comb begin
    found     = 1'b0;
    best_prio = 2'd3;
    for (int k = 0; k < 3; k++) begin
      if (elig[k] && (!found || prio_a[k] < best_prio)) begin
        best_prio = prio_a[k];
        found     = 1'b1;
      end
    end
    taken   = 1'b0;
    win_id  = 2'd0;
    win_len = 6'd0;
    scan    = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      scan = {1'b0, last_gnt_q} + 3'(i);
      if (scan >= 3'd3) scan = scan - 3'd3;
      for (int k = 0; k < 3; k++) begin
        if (!taken && scan == 3'(k) && elig[k] && prio_a[k] == best_prio) begin
          taken   = 1'b1;
          win_id  = 2'(k);
          win_len = dec_len(len_a[k]);
        end
      end
    end
  end

  assign beat = (state_q == XFER) && bus.f2a_rdy_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      gnt_id_q   <= 2'd0;
      gnt_len_q  <= 6'd0;
      cnt_q      <= 6'd0;
      last_gnt_q <= 2'd2;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      gnt_len_q  <= gnt_len_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    gnt_len_d  = gnt_len_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: if (any_elig) state_d = ARB;
      ARB: begin
        if (any_elig) begin
          state_d    = XFER;
          gnt_id_d   = win_id;
          gnt_len_d  = win_len;
          cnt_d      = 6'd0;
          last_gnt_d = win_id;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == gnt_len_q - 6'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.a2f_val_o  = 1'b0;
    bus.a2f_data_o = '0;
    bus.a2f_id_o   = 2'd0;
    bus.a2f_len_o  = 6'd0;
    bus.a2f_sop_o  = 1'b0;
    bus.a2f_eop_o  = 1'b0;
    bus.slv_rd_o   = 3'b000;
    bus.busy_o     = (state_q != IDLE);
    if (state_q == XFER) begin
      bus.a2f_val_o = 1'b1;
      bus.a2f_id_o  = gnt_id_q;
      bus.a2f_len_o = gnt_len_q;
      bus.a2f_sop_o = (cnt_q == 6'd0);
      bus.a2f_eop_o = (cnt_q == gnt_len_q - 6'd1);
      case (gnt_id_q)
        2'd0: begin
          bus.a2f_data_o  = bus.slv_data_i[DW-1:0];
          bus.slv_rd_o[0] = beat;
        end
        2'd1: begin
          bus.a2f_data_o  = bus.slv_data_i[2*DW-1:DW];
          bus.slv_rd_o[1] = beat;
        end
        default: begin
          bus.a2f_data_o  = bus.slv_data_i[3*DW-1:2*DW];
          bus.slv_rd_o[2] = beat;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_pkt_arbiter.sv
// Randomised bench for mcdf_pkt_arbiter: FIFO queues feed the DUT, a packet-level
// reference model predicts every output each cycle.
module tb_mcdf_pkt_arbiter;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mcdf_pkt_arbiter_if #(.DW(32), .CW(6)) bus ();

  mcdf_pkt_arbiter #(.DW(32), .CW(6)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  logic [31:0] fq [3][$];
  bit          refill [3];
  logic [2:0]  en;
  int          prio [3];
  int          lcode [3];
  logic        rdy;

  int n_chk = 0;
  int n_fail = 0;
  int pops [3];
  int eop_cnt;
  int obs_gnt [$];
  bit seen_val;
  bit pop_req [3];

  // Reference model: phase 0 = waiting, 1 = choosing, 2 = sending a packet.
  int m_ph, m_gid, m_glen, m_cnt, m_last;
  int n_ph, n_gid, n_glen, n_cnt, n_last;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  function automatic int dlen(input int c);
    return (c == 0) ? 4 : (c == 1) ? 8 : (c == 2) ? 16 : 32;
  endfunction

  task automatic drive();
    bus.slv_en_i  = en;
    bus.f2a_rdy_i = rdy;
    for (int k = 0; k < 3; k++) begin
      bus.slv_prio_i[2*k +: 2] = 2'(prio[k]);
      bus.slv_len_i[3*k +: 3]  = 3'(lcode[k]);
      bus.slv_cnt_i[6*k +: 6]  = 6'(fq[k].size());
      bus.slv_data_i[32*k +: 32] = (fq[k].size() > 0) ? fq[k][0] : 32'h0;
    end
  endtask

  task automatic push(input int k, input int n);
    repeat (n) fq[k].push_back($urandom);
  endtask

  task automatic model_reset();
    m_ph = 0; m_gid = 0; m_glen = 0; m_cnt = 0; m_last = 2;
    for (int k = 0; k < 3; k++) pop_req[k] = 1'b0;
  endtask

  task automatic sample_and_check();
    bit xf;
    bit el [3];
    bit any;
    int best, bkey, key;
    xf = (m_ph == 2);
    chk("val",  bus.a2f_val_o, xf);
    chk("data", bus.a2f_data_o, (xf && fq[m_gid].size() > 0) ? fq[m_gid][0] : 32'h0);
    chk("id",   bus.a2f_id_o, xf ? m_gid : 0);
    chk("len",  bus.a2f_len_o, xf ? m_glen : 0);
    chk("sop",  bus.a2f_sop_o, xf && m_cnt == 0);
    chk("eop",  bus.a2f_eop_o, xf && m_cnt == m_glen - 1);
    chk("rd",   bus.slv_rd_o, (xf && rdy) ? (1 << m_gid) : 0);
    chk("busy", bus.busy_o, m_ph != 0);

    seen_val = bus.a2f_val_o;
    for (int k = 0; k < 3; k++) begin
      pop_req[k] = bus.slv_rd_o[k];
      if (bus.slv_rd_o[k]) pops[k]++;
    end
    if (bus.a2f_val_o && rdy && bus.a2f_sop_o) obs_gnt.push_back(int'(bus.a2f_id_o));
    if (bus.a2f_val_o && rdy && bus.a2f_eop_o) eop_cnt++;

    n_ph = m_ph; n_gid = m_gid; n_glen = m_glen; n_cnt = m_cnt; n_last = m_last;
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      el[k] = en[k] && (fq[k].size() >= dlen(lcode[k]));
      any |= el[k];
    end
    case (m_ph)
      0: if (any) n_ph = 1;
      1: begin
        if (any) begin
          best = 0; bkey = 1000;
          for (int k = 0; k < 3; k++) begin
            key = prio[k] * 3 + ((k - m_last + 2) % 3);
            if (el[k] && key < bkey) begin bkey = key; best = k; end
          end
          n_gid = best; n_glen = dlen(lcode[best]); n_cnt = 0; n_last = best; n_ph = 2;
        end else n_ph = 0;
      end
      default: begin
        if (rdy) begin
          if (m_cnt == m_glen - 1) n_ph = 0;
          else n_cnt = m_cnt + 1;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk_i);
    sample_and_check();
    @(posedge clk_i);
    #1;
    m_ph = n_ph; m_gid = n_gid; m_glen = n_glen; m_cnt = n_cnt; m_last = n_last;
    for (int k = 0; k < 3; k++) begin
      if (pop_req[k] && fq[k].size() > 0) void'(fq[k].pop_front());
      pop_req[k] = 1'b0;
      if (refill[k]) while (fq[k].size() < 32) fq[k].push_back($urandom);
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset();
    rstn_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    drive();
  endtask

  task automatic quiesce();
    int k;
    en = 3'b000;
    rdy = 1'b1;
    for (int c = 0; c < 3; c++) refill[c] = 1'b0;
    drive();
    k = 0;
    while ((m_ph != 0 || bus.busy_o) && k < 100) begin
      step();
      k++;
    end
    chk("quiesce_busy", bus.busy_o, 0);
    for (int c = 0; c < 3; c++) fq[c].delete();
    drive();
  endtask

  task automatic clear_stats();
    obs_gnt.delete();
    eop_cnt = 0;
    for (int c = 0; c < 3; c++) pops[c] = 0;
  endtask

  initial begin
    int k, c2;
    en = 3'b000; rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin prio[c] = 0; lcode[c] = 0; refill[c] = 1'b0; end
    model_reset();
    clear_stats();
    drive();
    #2;
    chk("rst_val",  bus.a2f_val_o, 0);
    chk("rst_rd",   bus.slv_rd_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_data", bus.a2f_data_o, 0);
    apply_reset();

    // T1: single 8-word packet on ch0
    lcode[0] = 1; en = 3'b001; push(0, 8); drive();
    clear_stats();
    run(14);
    chk("t1_pops", pops[0], 8);
    chk("t1_grants", obs_gnt.size(), 1);
    chk("t1_eops", eop_cnt, 1);

    // T2: strict priority order, then with swapped priorities
    quiesce(); clear_stats();
    en = 3'b111; prio[0] = 0; prio[1] = 1; prio[2] = 2;
    for (int c = 0; c < 3; c++) begin lcode[c] = 0; push(c, 4); end
    drive(); run(25);
    for (int c = 0; c < 3; c++) push(c, 4);
    drive(); run(25);
    prio[0] = 2; prio[1] = 0; prio[2] = 1;
    for (int c = 0; c < 3; c++) push(c, 4);
    drive(); run(25);
    chk("t2_count", obs_gnt.size(), 9);
    if (obs_gnt.size() == 9) begin
      chk("t2_g0", obs_gnt[0], 0); chk("t2_g1", obs_gnt[1], 1); chk("t2_g2", obs_gnt[2], 2);
      chk("t2_g3", obs_gnt[3], 0); chk("t2_g4", obs_gnt[4], 1); chk("t2_g5", obs_gnt[5], 2);
      chk("t2_g6", obs_gnt[6], 1); chk("t2_g7", obs_gnt[7], 2); chk("t2_g8", obs_gnt[8], 0);
    end

    // T3: round-robin between equal-priority ch0/ch1, ch2 starved
    quiesce();
    en = 3'b111; prio[0] = 0; prio[1] = 0; prio[2] = 1;
    for (int c = 0; c < 3; c++) begin lcode[c] = 0; refill[c] = 1'b1; push(c, 32); end
    apply_reset(); clear_stats();
    run(60);
    chk("t3_enough", obs_gnt.size() >= 8, 1);
    c2 = 0;
    foreach (obs_gnt[i]) begin
      if (i < 8) chk("t3_alt", obs_gnt[i], i % 2);
      if (obs_gnt[i] == 2) c2++;
    end
    chk("t3_no_ch2", c2, 0);

    // T4: exact-length threshold and latency; disabled channel never granted
    quiesce(); clear_stats();
    prio[0] = 0; lcode[0] = 1; en = 3'b001; push(0, 7); drive();
    run(10);
    chk("t4_idle_busy", bus.busy_o, 0);
    chk("t4_no_grant", obs_gnt.size(), 0);
    push(0, 1); drive();
    step();
    k = 0;
    while (!seen_val && k < 10) begin k++; step(); end
    chk("t4_latency", k, 2);
    run(15);
    chk("t4_pops", pops[0], 8);
    en = 3'b000; push(0, 32); drive(); clear_stats();
    run(30);
    chk("t4_dis_grant", obs_gnt.size(), 0);
    chk("t4_dis_busy", bus.busy_o, 0);

    // T5: stalls during a 16-word ch1 packet
    quiesce(); clear_stats();
    prio[1] = 0; lcode[1] = 2; en = 3'b010; push(1, 16); drive();
    for (int i = 0; i < 70; i++) begin
      rdy = (i % 4 == 0) || (i % 4 == 3);
      drive();
      step();
    end
    rdy = 1'b1; drive();
    chk("t5_pops", pops[1], 16);
    chk("t5_eops", eop_cnt, 1);
    chk("t5_empty", fq[1].size(), 0);

    // T6: reset during beat 3 abandons the packet; a fresh one follows
    quiesce(); clear_stats();
    prio[0] = 0; lcode[0] = 1; en = 3'b001; push(0, 16); drive();
    k = 0;
    while (pops[0] < 2 && k < 20) begin step(); k++; end
    chk("t6_reach_beat3", pops[0], 2);
    rstn_i = 1'b0;
    #1;
    chk("t6_val",  bus.a2f_val_o, 0);
    chk("t6_rd",   bus.slv_rd_o, 0);
    chk("t6_sop",  bus.a2f_sop_o, 0);
    chk("t6_eop",  bus.a2f_eop_o, 0);
    chk("t6_data", bus.a2f_data_o, 0);
    chk("t6_id",   bus.a2f_id_o, 0);
    chk("t6_len",  bus.a2f_len_o, 0);
    chk("t6_busy", bus.busy_o, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    drive();
    obs_gnt.delete();
    run(20);
    chk("t6_regrant", obs_gnt.size(), 1);
    chk("t6_pops", pops[0], 10);
    chk("t6_left", fq[0].size(), 6);

    // Random traffic with mid-packet control changes and random backpressure
    quiesce();
    en = 3'b111;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) en = 3'($urandom);
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(15) == 0) prio[c] = $urandom_range(3);
        if ($urandom_range(15) == 0) lcode[c] = $urandom_range(7);
        if (fq[c].size() < 32 && $urandom_range(2) == 0) push(c, 1);
      end
      rdy = ($urandom_range(3) != 0);
      drive();
      step();
    end
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
